test_status_monitor: RTL and testbench

TEST_STATUS_MONITOR -- requirements
Module: test_status_monitor

---
 rtl/test_mon_pkg.sv | 19 +
 rtl/test_mon_channel.sv | 43 ++++
 rtl/test_status_monitor.sv | 156 +++++++++++++++
 tb/tb_test_status_monitor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_mon_pkg.sv
// Shared types and default parameter values for the test status monitor.
// Optional feature macro: TEST_MON_HEARTBEAT_EN (see test_status_monitor).
package test_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } mon_state_e;

    localparam int DEF_NUM_CH     = 1;
    localparam int DEF_RESET_HOLD = 30;
    localparam int DEF_TIMEOUT    = 2000;
    localparam int DEF_CNT_W      = 32;
    localparam int CSR_W          = 32;
    localparam int CODE_W         = 31;

endpackage

// File: rtl/test_mon_channel.sv
// One monitored tohost channel: remembers whether it has finished and its exit code.
// Exposes the next-cycle view so the top can decide DONE in the finishing cycle.
module test_mon_channel
    import test_mon_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              run,
    input  logic              wr_valid,
    input  logic [CSR_W-1:0]  wr_data,
    output logic              fin_nx,
    output logic [CODE_W-1:0] code_nx
);

    logic              finished;
    logic [CODE_W-1:0] code;
    logic              finish_now;

    assign finish_now = run && wr_valid && wr_data[0] && !finished;
    assign fin_nx     = finished || finish_now;
    assign code_nx    = finish_now ? wr_data[CSR_W-1:1] : code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finished <= 1'b0;
        end else if (clear) begin
            finished <= 1'b0;
        end else if (finish_now) begin
            finished <= 1'b1;
        end
    end

    // Code is only consulted once finished is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (clear) begin
            code <= '0;
        end else if (finish_now) begin
            code <= wr_data[CSR_W-1:1];
        end
    end

endmodule

// File: rtl/test_status_monitor.sv
// Runs a CPU test: holds cpu_rst, watches per-channel tohost writes, reports pass/fail/timeout.
// Define TEST_MON_HEARTBEAT_EN to turn the watchdog into an inactivity timeout.
module test_status_monitor
    import test_mon_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int RESET_HOLD = DEF_RESET_HOLD,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_CH-1:0]       csr_wr_valid,
    input  logic [CSR_W*NUM_CH-1:0] csr_wr_data,
    output logic                    cpu_rst,
    output logic                    running,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [NUM_CH-1:0]       fail_mask,
    output logic [CODE_W-1:0]       fail_code,
    output logic [CNT_W-1:0]        cycle_count
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    mon_state_e        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic [WD_W-1:0]   wd_nx;
    logic              wd_reload;
    logic              wd_expire;
    logic              ch_clear;
    logic              in_run;

    logic [NUM_CH-1:0] ch_fin_nx;
    logic [CODE_W-1:0] ch_code_nx [NUM_CH];
    logic              all_fin;
    logic [NUM_CH-1:0] mask_nx;
    logic [CODE_W-1:0] code_sel;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_run   = (state == ST_RUN);
    assign ch_clear = start && ((state == ST_IDLE) || (state == ST_DONE));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        test_mon_channel u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (ch_clear),
            .run      (in_run),
            .wr_valid (csr_wr_valid[i]),
            .wr_data  (csr_wr_data[CSR_W*i +: CSR_W]),
            .fin_nx   (ch_fin_nx[i]),
            .code_nx  (ch_code_nx[i])
        );
    end

`ifdef TEST_MON_HEARTBEAT_EN
    assign wd_reload = |csr_wr_valid;
`else
    assign wd_reload = 1'b0;
`endif

    assign wd_nx     = wd_reload ? '0 : wd_cnt + 1'b1;
    assign wd_expire = !wd_reload && (wd_cnt == WD_W'(TIMEOUT - 1));

    // Results as they will stand after this cycle's captures.
    always_comb begin
        logic found;
        logic bad;
        all_fin  = 1'b1;
        mask_nx  = '0;
        code_sel = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            bad        = ch_fin_nx[i] && (ch_code_nx[i] != '0);
            all_fin    = all_fin && ch_fin_nx[i];
            mask_nx[i] = bad;
            if (bad && !found) begin
                code_sel = ch_code_nx[i];
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            wd_cnt      <= '0;
            cpu_rst     <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_mask   <= '0;
            fail_code   <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state       <= ST_HOLD;
                        hold_cnt    <= '0;
                        cpu_rst     <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        fail_mask   <= '0;
                        fail_code   <= '0;
                        cycle_count <= '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
                        state   <= ST_RUN;
                        cpu_rst <= 1'b0;
                        running <= 1'b1;
                        wd_cnt  <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    cycle_count <= sat_inc(cycle_count);
                    wd_cnt      <= wd_nx;
                    // Completion takes priority over a watchdog expiring in the same cycle.
                    if (all_fin) begin
                        state     <= ST_DONE;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (mask_nx == '0);
                        fail_mask <= mask_nx;
                        fail_code <= code_sel;
                    end else if (wd_expire) begin
                        state     <= ST_DONE;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        timeout   <= 1'b1;
                        pass      <= 1'b0;
                        fail_mask <= mask_nx;
                        fail_code <= code_sel;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_status_monitor.sv
// Randomized bench for test_status_monitor against a run-level reference model.
// Honours TEST_MON_HEARTBEAT_EN the same way the design does.
module tb_test_status_monitor;

    localparam int NUM_CH     = 2;
    localparam int RESET_HOLD = 30;
    localparam int TIMEOUT    = 2000;
    localparam int CNT_W      = 32;
    localparam int LIMIT      = 8000;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic [NUM_CH-1:0]        csr_wr_valid;
    logic [32*NUM_CH-1:0]     csr_wr_data;
    logic                     cpu_rst, running, done, pass, timeout;
    logic [NUM_CH-1:0]        fail_mask;
    logic [30:0]              fail_code;
    logic [CNT_W-1:0]         cycle_count;

    test_status_monitor #(
        .NUM_CH(NUM_CH), .RESET_HOLD(RESET_HOLD), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .csr_wr_valid(csr_wr_valid), .csr_wr_data(csr_wr_data),
        .cpu_rst(cpu_rst), .running(running), .done(done), .pass(pass),
        .timeout(timeout), .fail_mask(fail_mask), .fail_code(fail_code),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          k;
        int          ch;
        logic [31:0] d;
    } wr_t;

    wr_t sched[$];
    int  start_at_k;
    int  n_checks = 0;
    int  n_errors = 0;

    int                exp_k_end;
    logic              exp_to, exp_pass;
    logic [NUM_CH-1:0] exp_mask;
    logic [30:0]       exp_code;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Writes scheduled for RUN cycle k (a later entry for the same channel wins).
    task automatic decode(input int k, output logic [NUM_CH-1:0] v,
                          output logic [NUM_CH-1:0][31:0] d);
        v = '0;
        d = '0;
        foreach (sched[n]) begin
            if (sched[n].k == k) begin
                v[sched[n].ch] = 1'b1;
                d[sched[n].ch] = sched[n].d;
            end
        end
    endtask

    // Expected outcome of a run, walked one RUN cycle at a time.
    task automatic model();
        bit                       fin[NUM_CH];
        logic [30:0]              code[NUM_CH];
        logic [NUM_CH-1:0]        v;
        logic [NUM_CH-1:0][31:0]  d;
        int                       base;
        bit                       all, reload;
        base      = 0;
        exp_to    = 1'b0;
        exp_k_end = -1;
        for (int c = 0; c < NUM_CH; c++) begin
            fin[c]  = 1'b0;
            code[c] = '0;
        end
        for (int k = 0; k < LIMIT; k++) begin
            decode(k, v, d);
            for (int c = 0; c < NUM_CH; c++)
                if (v[c] && d[c][0] && !fin[c]) begin
                    fin[c]  = 1'b1;
                    code[c] = d[c][31:1];
                end
            all = 1'b1;
            for (int c = 0; c < NUM_CH; c++) all = all && fin[c];
            if (all) begin
                exp_k_end = k;
                break;
            end
            reload = 1'b0;
`ifdef TEST_MON_HEARTBEAT_EN
            reload = (v != '0);
`endif
            if (reload) base = k + 1;
            else if (k - base + 1 >= TIMEOUT) begin
                exp_to    = 1'b1;
                exp_k_end = k;
                break;
            end
        end
        exp_mask = '0;
        exp_code = '0;
        for (int c = NUM_CH - 1; c >= 0; c--)
            if (fin[c] && code[c] != 0) begin
                exp_mask[c] = 1'b1;
                exp_code    = code[c];
            end
        exp_pass = !exp_to && (exp_mask == '0);
    endtask

    task automatic noise();
        csr_wr_valid = NUM_CH'($urandom);
        csr_wr_data  = {$urandom, $urandom} | 64'h0000_0001_0000_0001;
    endtask

    task automatic check_results(input string name);
        check({name, ".timeout"}, 64'(timeout), 64'(exp_to));
        check({name, ".pass"}, 64'(pass), 64'(exp_pass));
        check({name, ".fail_mask"}, 64'(fail_mask), 64'(exp_mask));
        check({name, ".fail_code"}, 64'(fail_code), 64'(exp_code));
        check({name, ".cycle_count"}, 64'(cycle_count), 64'(exp_k_end + 1));
        check({name, ".cpu_rst"}, 64'(cpu_rst), 64'd0);
        check({name, ".running"}, 64'(running), 64'd0);
    endtask

    task automatic run_test(input string name);
        logic [NUM_CH-1:0]       v;
        logic [NUM_CH-1:0][31:0] d;
        int                      hold_hi;
        bit                      seen;
        model();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        hold_hi = 0;
        seen    = 1'b0;
        for (int j = 0; j < RESET_HOLD + LIMIT + 2 && !seen; j++) begin
            if (j < RESET_HOLD) begin
                noise();
            end else begin
                decode(j - RESET_HOLD, v, d);
                csr_wr_valid = v;
                csr_wr_data  = d;
                start        = (j - RESET_HOLD == start_at_k);
            end
            @(negedge clk);
            if (j == 0) begin
                check({name, ".clr_done"}, 64'(done), 64'd0);
                check({name, ".clr_mask"}, 64'(fail_mask | NUM_CH'(timeout)), 64'd0);
                check({name, ".clr_count"}, 64'(cycle_count), 64'd0);
            end
            if (j < RESET_HOLD) hold_hi += int'(cpu_rst);
            if (j == RESET_HOLD) begin
                check({name, ".hold_len"}, 64'(hold_hi), 64'(RESET_HOLD));
                check({name, ".run_rst"}, 64'({running, cpu_rst}), 64'b10);
            end
            if (done) begin
                seen = 1'b1;
                check({name, ".done_cycle"}, 64'(j), 64'(RESET_HOLD + exp_k_end + 1));
                check_results(name);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!seen) begin
            check({name, ".done_seen"}, 64'd0, 64'd1);
        end else begin
            for (int i = 0; i < 3; i++) begin
                noise();
                @(posedge clk); #1;
            end
            @(negedge clk);
            check({name, ".held_done"}, 64'(done), 64'd1);
            check_results({name, ".held"});
        end
        csr_wr_valid = '0;
        csr_wr_data  = '0;
    endtask

    task automatic add(input int k, input int ch, input logic [31:0] d);
        wr_t w;
        w.k  = k;
        w.ch = ch;
        w.d  = d;
        sched.push_back(w);
    endtask

    task automatic gen_random();
        logic [30:0] code;
        sched.delete();
        start_at_k = ($urandom_range(0, 1) == 1) ? 3 : -1;
        for (int c = 0; c < NUM_CH; c++) begin
            int n;
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                code = ($urandom_range(0, 2) == 0) ? 31'($urandom) : 31'd0;
                add($urandom_range(5, 400), c, {code, 1'($urandom_range(0, 1))});
            end
            if ($urandom_range(0, 7) != 0) begin
                code = ($urandom_range(0, 2) == 0) ? 31'($urandom_range(1, 255)) : 31'd0;
                add($urandom_range(5, 400), c, {code, 1'b1});
            end
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        csr_wr_valid = '0;
        csr_wr_data  = '0;
        start_at_k   = -1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.cpu_rst", 64'(cpu_rst), 64'd1);
        check("rst.running", 64'(running), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.pass", 64'(pass), 64'd0);
        check("rst.timeout", 64'(timeout), 64'd0);
        check("rst.fail_mask", 64'(fail_mask), 64'd0);
        check("rst.fail_code", 64'(fail_code), 64'd0);
        check("rst.cycle_count", 64'(cycle_count), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        sched.delete(); add(50, 0, 32'h1); add(50, 1, 32'h1);
        run_test("basic_pass");

        sched.delete(); add(10, 0, 32'h1); add(20, 1, 32'h7);
        run_test("ch1_fail");

        sched.delete(); add(50, 0, 32'h1); add(50, 1, 32'h1);
        run_test("restart");

        sched.delete();
        run_test("no_writes");

        sched.delete(); add(TIMEOUT - 1, 0, 32'h1); add(TIMEOUT - 1, 1, 32'h1);
        run_test("finish_on_expiry");

        sched.delete(); add(TIMEOUT - 1, 0, 32'h5);
        run_test("partial_expiry");

        sched.delete();
        for (int k = 1500; k < 5000; k += 1500) add(k, 0, 32'h0);
        add(5000, 0, 32'h1); add(5000, 1, 32'h1);
        run_test("heartbeat");

        sched.delete(); add(4, 1, 32'h6); add(7, 0, 32'hB); add(7, 1, 32'h3); add(8, 0, 32'h1);
        run_test("same_cycle");

        for (int r = 0; r < 6; r++) begin
            gen_random();
            run_test($sformatf("rand%0d", r));
        end
        start_at_k = -1;

        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (RESET_HOLD + 10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort.cpu_rst", 64'(cpu_rst), 64'd1);
        check("abort.done", 64'(done), 64'd0);
        check("abort.running", 64'(running), 64'd0);
        check("abort.cycle_count", 64'(cycle_count), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        noise();
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("abort.idle", 64'({done, cpu_rst, running}), 64'b010);
        csr_wr_valid = '0;
        csr_wr_data  = '0;

        sched.delete(); add(50, 0, 32'h1); add(50, 1, 32'h1);
        run_test("after_abort");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
